layer_controller: RTL and testbench
===================================

Name: layer_controller

Overview:
Sequences one fully-connected layer of neuron instances. It accepts the layer's input vector as a ready/valid stream, broadcasts each element to all neurons, and waits for every neuron's outvalid pulse. It captures each neuron's activation into a local buffer, then serialises the buffer to the next layer over a ready/valid stream with a last flag. It sits between consecutive neuron layers in the network top level.

Parameters:
numInputs, 784, elements per input vector; equals the neurons' numWeight
numNeurons, 30, neurons in the controlled layer (>=1)
dataWidth, 16, activation width
timeoutCycles, 1024, maximum cycles in WAIT before abort

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_data  in  dataWidth  upstream activation
in_valid  in  1  upstream valid
in_ready  out  1  controller accepts in_data
n_input  out  dataWidth  broadcast to every neuron's myinput
n_input_valid  out  1  broadcast to every neuron's myinputValid
n_out  in  numNeurons*dataWidth  packed neuron outputs; neuron k at [k*dataWidth+:dataWidth]
n_outvalid  in  numNeurons  per-neuron outvalid pulses
out_data  out  dataWidth  downstream activation
out_valid  out  1  downstream valid
out_ready  in  1  downstream ready
out_last  out  1  high with the final element (index numNeurons-1)
busy  out  1  state != IDLE
layer_done  out  1  one-cycle pulse when the final element is transferred
err  out  1  sticky error flag; cleared only by rst

Behaviour:
- Reset (rst=1 at a posedge):
  - All outputs go to 0: in_ready, n_input, n_input_valid, out_valid, out_data, out_last, busy, layer_done, err.
  - State goes to IDLE; counters and the capture mask clear.
  - Reset mid-operation abandons the vector; no partial output is emitted.
- States: IDLE, FEED, WAIT, DRAIN.
- IDLE:
  - in_ready=0.
  - Go to FEED when in_valid=1. The element is not consumed in this cycle.
- FEED:
  - in_ready=1.
  - Transfer when in_valid & in_ready. Registered: n_input<=in_data and n_input_valid<=1 one cycle later; otherwise n_input_valid<=0.
  - Upstream bubbles are allowed. Neurons tolerate gaps because they accumulate only on valid.
  - in_cnt counts transfers. On transfer numInputs, go to WAIT and in_ready drops the same edge.
  - No extra element is ever accepted.
- WAIT:
  - in_ready=0.
  - Each cycle, for every k with n_outvalid[k]=1 and mask[k]=0: buf[k]<=n_out slice k and mask[k]<=1. Several bits in one cycle are all captured.
  - A repeat pulse on an already-captured neuron sets err; the first value is kept.
  - Once mask is all ones (including bits set this cycle), go to DRAIN next cycle.
  - wait_cnt counts WAIT cycles. On reaching timeoutCycles: set err, fill uncaptured entries with 0, go to DRAIN.
- DRAIN:
  - out_valid=1, out_data=buf[idx], out_last=(idx==numNeurons-1).
  - Transfer on out_valid & out_ready. out_data and out_last stay stable while out_ready=0.
  - After the last transfer: layer_done pulses for 1 cycle, state goes to IDLE, mask/idx/counters clear.
  - numNeurons=1: the first element is also last.
- n_outvalid in IDLE/FEED/DRAIN: sets err; data is ignored.
- Throughput:
  - Minimum latency from the first in_data transfer to the first out_valid is numInputs + neuron latency + 1.
  - The next vector can start in the cycle after layer_done.
- Counter widths: $clog2(numInputs+1), $clog2(numNeurons), $clog2(timeoutCycles+1).

Decomposition:
- Shared package nn_ctrl_pkg:
  - state encoding localparams ST_IDLE=2'd0, ST_FEED=2'd1, ST_WAIT=2'd2, ST_DRAIN=2'd3;
  - clog2-based width helper.
- One sub-module: layer_out_buffer.
  - Holds the numNeurons x dataWidth register array plus the capture mask.
  - Inputs: capture, clear, timeout-fill, read index.
  - Outputs: all_captured, dup_error, read data.
- The FSM and counters stay in layer_controller.

Test Plan:
- Test configuration: numInputs=4, numNeurons=3, behavioural neuron model with outvalid 6 cycles after the 4th input.
- Nominal: feed 1,2,3,4 back-to-back; neurons return 0x0010,0x0020,0x0030 in the same cycle; out_ready=1.
  - Required: n_input_valid high exactly 4 cycles with values 1..4.
  - Required: out_data 0x0010,0x0020,0x0030 on consecutive cycles; out_last only on the 3rd; layer_done one pulse; err=0.
- Bubbles and staggered outputs: in_valid pattern 1,0,1,1,0,1; outvalid for neurons 2,0,1 on different cycles.
  - Required: exactly 4 n_input_valid pulses; output order is neuron 0,1,2 regardless of arrival order.
- Backpressure: out_ready toggling 0,1,0,0,1,1 in DRAIN.
  - Required: each element is held stable until accepted; no duplicates or drops; in_ready=0 throughout DRAIN.
- Timeout (timeoutCycles=16): neuron 1 never pulses.
  - Required: err=1 after 16 WAIT cycles; output 0x0010,0x0000,0x0030; layer_done pulses.
- Reset mid-FEED after 2 inputs, then a fresh 4-element vector.
  - Required: all outputs 0 after reset; the second vector completes normally with no residue from the first.
- Duplicate/spurious outvalid: neuron 0 pulses twice in WAIT, then once in IDLE.
  - Required: the first value is kept; err=1 and stays set until rst.

Source files
------------

// File: rtl/nn_ctrl_pkg.sv
// Shared definitions for the neuron-layer sequencing logic: controller states and
// a counter-width helper.
package nn_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } ctrl_state_e;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/layer_out_buffer.sv
// Per-neuron activation capture buffer with a capture mask. Each entry is taken
// from the first outvalid pulse seen while capturing; later pulses are flagged.
module layer_out_buffer #(
    parameter int unsigned numNeurons = 30,
    parameter int unsigned dataWidth  = 16,
    parameter int unsigned IdxW       = 5
) (
    input  logic                            clk,
    input  logic                            clear,
    input  logic                            capture,
    input  logic                            fill,
    input  logic [numNeurons-1:0]           cap_valid,
    input  logic [numNeurons*dataWidth-1:0] cap_data,
    input  logic [IdxW-1:0]                 rd_idx,
    output logic                            all_captured,
    output logic                            dup_error,
    output logic [dataWidth-1:0]            rd_data
);

    logic [numNeurons-1:0] mask_q, mask_d;
    logic [numNeurons-1:0] take;
    logic [dataWidth-1:0]  mem_q [numNeurons];
    logic [dataWidth-1:0]  mem_d [numNeurons];

    always_comb begin
        take   = capture ? (cap_valid & ~mask_q) : '0;
        mask_d = mask_q;
        for (int k = 0; k < numNeurons; k++) begin
            mem_d[k] = mem_q[k];
            if (take[k]) begin
                mem_d[k]  = cap_data[k*dataWidth +: dataWidth];
                mask_d[k] = 1'b1;
            end else if (fill && !mask_q[k]) begin
                // Timed-out neurons read back as zero.
                mem_d[k]  = '0;
                mask_d[k] = 1'b1;
            end
        end
        if (clear) begin
            mask_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        mask_q <= mask_d;
        mem_q  <= mem_d;
    end

    assign all_captured = &(mask_q | take);
    assign dup_error    = capture && |(cap_valid & mask_q);
    assign rd_data      = mem_q[rd_idx];

endmodule

// File: rtl/layer_controller.sv
// Sequences one fully-connected layer: broadcasts the input vector to all neurons,
// collects every neuron's activation, then streams them out in neuron order.
module layer_controller
    import nn_ctrl_pkg::*;
#(
    parameter int unsigned numInputs     = 784,
    parameter int unsigned numNeurons    = 30,
    parameter int unsigned dataWidth     = 16,
    parameter int unsigned timeoutCycles = 1024
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [dataWidth-1:0]            in_data,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic [dataWidth-1:0]            n_input,
    output logic                            n_input_valid,
    input  logic [numNeurons*dataWidth-1:0] n_out,
    input  logic [numNeurons-1:0]           n_outvalid,
    output logic [dataWidth-1:0]            out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            out_last,
    output logic                            busy,
    output logic                            layer_done,
    output logic                            err
);

    localparam int unsigned InW   = cnt_width(numInputs + 1);
    localparam int unsigned IdxW  = cnt_width(numNeurons);
    localparam int unsigned WaitW = cnt_width(timeoutCycles + 1);

    localparam logic [InW-1:0]   InLast   = InW'(numInputs - 1);
    localparam logic [IdxW-1:0]  IdxLast  = IdxW'(numNeurons - 1);
    localparam logic [WaitW-1:0] WaitLast = WaitW'(timeoutCycles - 1);

    ctrl_state_e          state_q, state_d;
    logic [InW-1:0]       in_cnt_q, in_cnt_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic [WaitW-1:0]     wait_cnt_q, wait_cnt_d;
    logic [dataWidth-1:0] n_input_q, n_input_d;
    logic                 n_input_valid_q, n_input_valid_d;
    logic                 layer_done_q, layer_done_d;
    logic                 err_q, err_d;

    logic                 fill, clear;
    logic                 all_captured, dup_error;
    logic [dataWidth-1:0] rd_data;

    always_comb begin
        state_d         = state_q;
        in_cnt_d        = in_cnt_q;
        idx_d           = idx_q;
        wait_cnt_d      = wait_cnt_q;
        n_input_d       = n_input_q;
        n_input_valid_d = 1'b0;
        layer_done_d    = 1'b0;
        err_d           = err_q;
        fill            = 1'b0;
        clear           = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (|n_outvalid) err_d = 1'b1;
                // The pending element is left on the bus and taken in FEED.
                if (in_valid) state_d = ST_FEED;
            end
            ST_FEED: begin
                if (|n_outvalid) err_d = 1'b1;
                if (in_valid) begin
                    n_input_d       = in_data;
                    n_input_valid_d = 1'b1;
                    if (in_cnt_q == InLast) begin
                        in_cnt_d   = '0;
                        wait_cnt_d = '0;
                        state_d    = ST_WAIT;
                    end else begin
                        in_cnt_d = in_cnt_q + 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (dup_error) err_d = 1'b1;
                wait_cnt_d = wait_cnt_q + 1'b1;
                if (all_captured) begin
                    wait_cnt_d = '0;
                    state_d    = ST_DRAIN;
                end else if (wait_cnt_q == WaitLast) begin
                    fill       = 1'b1;
                    err_d      = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (|n_outvalid) err_d = 1'b1;
                if (out_ready) begin
                    if (idx_q == IdxLast) begin
                        idx_d        = '0;
                        layer_done_d = 1'b1;
                        clear        = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            in_cnt_q        <= '0;
            idx_q           <= '0;
            wait_cnt_q      <= '0;
            n_input_q       <= '0;
            n_input_valid_q <= 1'b0;
            layer_done_q    <= 1'b0;
            err_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            in_cnt_q        <= in_cnt_d;
            idx_q           <= idx_d;
            wait_cnt_q      <= wait_cnt_d;
            n_input_q       <= n_input_d;
            n_input_valid_q <= n_input_valid_d;
            layer_done_q    <= layer_done_d;
            err_q           <= err_d;
        end
    end

    layer_out_buffer #(
        .numNeurons (numNeurons),
        .dataWidth  (dataWidth),
        .IdxW       (IdxW)
    ) u_buf (
        .clk          (clk),
        .clear        (clear | rst),
        .capture      (state_q == ST_WAIT),
        .fill         (fill),
        .cap_valid    (n_outvalid),
        .cap_data     (n_out),
        .rd_idx       (idx_q),
        .all_captured (all_captured),
        .dup_error    (dup_error),
        .rd_data      (rd_data)
    );

    assign in_ready      = (state_q == ST_FEED);
    assign busy          = (state_q != ST_IDLE);
    assign out_valid     = (state_q == ST_DRAIN);
    assign out_data      = out_valid ? rd_data : '0;
    assign out_last      = out_valid && (idx_q == IdxLast);
    assign n_input       = n_input_q;
    assign n_input_valid = n_input_valid_q;
    assign layer_done    = layer_done_q;
    assign err           = err_q;

endmodule

// File: tb/tb_layer_controller.sv
// Self-checking bench for layer_controller: behavioural neuron stubs, a reference
// model of the layer sequencing rules, and directed plus randomized vectors.
module tb_layer_controller;

    localparam int NI = 4;
    localparam int NN = 3;
    localparam int DW = 16;
    localparam int TO = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [DW-1:0]     in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     n_input;
    logic              n_input_valid;
    logic [NN*DW-1:0]  n_out;
    logic [NN-1:0]     n_outvalid;
    logic [DW-1:0]     out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              busy;
    logic              layer_done;
    logic              err;

    always #5 clk = ~clk;

    layer_controller #(
        .numInputs     (NI),
        .numNeurons    (NN),
        .dataWidth     (DW),
        .timeoutCycles (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .n_input       (n_input),
        .n_input_valid (n_input_valid),
        .n_out         (n_out),
        .n_outvalid    (n_outvalid),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_last      (out_last),
        .busy          (busy),
        .layer_done    (layer_done),
        .err           (err)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: phases of the layer and what each rule makes visible.
    localparam int PI = 0, PF = 1, PW = 2, PD = 3;
    int            m_ph = PI, m_nacc, m_wcyc, m_idx, m_ngot;
    logic [DW-1:0] m_val [NN];
    bit            m_got [NN];
    bit            m_niv, m_done, m_err;
    logic [DW-1:0] m_ni;

    always @(posedge clk) begin
        m_niv  = 1'b0;
        m_done = 1'b0;
        if (rst) begin
            m_ph = PI; m_nacc = 0; m_wcyc = 0; m_idx = 0; m_err = 1'b0; m_ni = '0;
            for (int k = 0; k < NN; k++) begin m_got[k] = 1'b0; m_val[k] = '0; end
        end else begin
            case (m_ph)
                PI: begin
                    if (n_outvalid != 0) m_err = 1'b1;
                    if (in_valid) m_ph = PF;
                end
                PF: begin
                    if (n_outvalid != 0) m_err = 1'b1;
                    if (in_valid) begin
                        m_ni  = in_data;
                        m_niv = 1'b1;
                        m_nacc++;
                        if (m_nacc == NI) begin m_ph = PW; m_nacc = 0; m_wcyc = 0; end
                    end
                end
                PW: begin
                    m_wcyc++;
                    m_ngot = 0;
                    for (int k = 0; k < NN; k++) begin
                        if (n_outvalid[k]) begin
                            if (m_got[k]) m_err = 1'b1;
                            else begin m_got[k] = 1'b1; m_val[k] = n_out[k*DW +: DW]; end
                        end
                        if (m_got[k]) m_ngot++;
                    end
                    if (m_ngot == NN) begin
                        m_ph = PD; m_idx = 0;
                    end else if (m_wcyc == TO) begin
                        m_err = 1'b1;
                        for (int k = 0; k < NN; k++) if (!m_got[k]) m_val[k] = '0;
                        m_ph = PD; m_idx = 0;
                    end
                end
                default: begin
                    if (n_outvalid != 0) m_err = 1'b1;
                    if (out_ready) begin
                        if (m_idx == NN - 1) begin
                            m_done = 1'b1; m_ph = PI;
                            for (int k = 0; k < NN; k++) m_got[k] = 1'b0;
                        end else begin
                            m_idx++;
                        end
                    end
                end
            endcase
        end
    end

    bit chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", in_ready, m_ph == PF);
            chk("busy", busy, m_ph != PI);
            chk("n_input_valid", n_input_valid, m_niv);
            chk("n_input", n_input, m_ni);
            chk("out_valid", out_valid, m_ph == PD);
            chk("out_data", out_data, (m_ph == PD) ? m_val[m_idx] : 16'h0);
            chk("out_last", out_last, (m_ph == PD) && (m_idx == NN - 1));
            chk("layer_done", layer_done, m_done);
            chk("err", err, m_err);
        end
    end

    // Stimulus state: upstream vector, neuron stubs, downstream ready pattern.
    logic [DW-1:0] vec [NI];
    int            vpos, vi, ri, vmode, rmode;
    bit            vpat [6] = '{1, 0, 1, 1, 0, 1};
    bit            rpat [6] = '{0, 1, 0, 0, 1, 1};
    int            dly [NN];
    int            dupd [NN];
    logic [DW-1:0] nval [NN];
    bit            spur, quiet;
    int            cyc, fire_cyc, npulse, ndone;
    bit            ir_in_drain;
    logic [DW-1:0] niq [$];
    logic [DW-1:0] outq [$];
    bit            lastq [$];
    int            outcyc [$];

    task automatic step();
        logic [NN-1:0]    ov;
        logic [NN*DW-1:0] od;
        bit               v;
        @(negedge clk);
        cyc++;
        if (layer_done) ndone++;
        if (n_input_valid) begin
            niq.push_back(n_input);
            npulse++;
            if (npulse == NI) fire_cyc = cyc;
        end
        if (out_valid && in_ready) ir_in_drain = 1'b1;
        ov = '0;
        od = '0;
        for (int k = 0; k < NN; k++) begin
            bit first, second;
            first  = !quiet && fire_cyc >= 0 && dly[k] > 0 && cyc == fire_cyc + dly[k];
            second = !quiet && fire_cyc >= 0 && dupd[k] > 0 && cyc == fire_cyc + dupd[k];
            ov[k]  = first || second || spur;
            od[k*DW +: DW] = second ? ~nval[k] : nval[k];
        end
        n_outvalid = ov;
        n_out      = od;
        case (vmode)
            0:       v = 1'b1;
            1:       v = vpat[vi % 6];
            default: v = ($urandom_range(0, 3) != 0);
        endcase
        vi++;
        in_valid = !quiet && (vpos < NI) && v;
        in_data  = (vpos < NI) ? vec[vpos] : DW'($urandom);
        if (in_valid && in_ready) vpos++;
        case (rmode)
            0:       out_ready = 1'b1;
            1:       out_ready = rpat[ri % 6];
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
        if (out_valid) ri++;
        if (out_valid && out_ready) begin
            outq.push_back(out_data);
            lastq.push_back(out_last);
            outcyc.push_back(cyc);
        end
    endtask

    task automatic start_vec(input int vm, input int rm);
        vmode = vm; rmode = rm;
        vpos = 0; vi = 0; ri = 0; npulse = 0; fire_cyc = -1; ndone = 0;
        ir_in_drain = 1'b0; quiet = 1'b0; spur = 1'b0;
        niq.delete(); outq.delete(); lastq.delete(); outcyc.delete();
    endtask

    task automatic run_vec(input int vm, input int rm);
        int guard;
        start_vec(vm, rm);
        guard = 0;
        while (ndone == 0 && guard < 300) begin step(); guard++; end
        chk("vector_completes", ndone, 1);
        fire_cyc = -1;
        quiet = 1'b1;
        step(); step();
        chk("single_layer_done", ndone, 1);
    endtask

    task automatic chk_outs(input string name, input logic [DW-1:0] e0,
                            input logic [DW-1:0] e1, input logic [DW-1:0] e2);
        logic [DW-1:0] e [NN];
        e[0] = e0; e[1] = e1; e[2] = e2;
        chk({name, "_count"}, outq.size(), NN);
        for (int i = 0; i < NN && i < outq.size(); i++) begin
            chk({name, "_data"}, outq[i], e[i]);
            chk({name, "_last"}, lastq[i], i == NN - 1);
        end
    endtask

    task automatic set_neurons(input int d0, input int d1, input int d2,
                               input logic [DW-1:0] v0, input logic [DW-1:0] v1,
                               input logic [DW-1:0] v2);
        dly[0] = d0; dly[1] = d1; dly[2] = d2;
        nval[0] = v0; nval[1] = v1; nval[2] = v2;
        for (int k = 0; k < NN; k++) dupd[k] = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1; quiet = 1'b1;
        step(); step();
        chk_en = 1'b1;
        rst = 1'b0;
        step();
    endtask

    initial begin
        int guard;
        logic [DW-1:0] exp_o [NN];
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        n_outvalid = '0; n_out = '0; spur = 1'b0; quiet = 1'b1; fire_cyc = -1;
        cyc = 0; vmode = 0; rmode = 0;
        set_neurons(6, 6, 6, 16'h0010, 16'h0020, 16'h0030);

        do_reset();
        chk("reset_in_ready", in_ready, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_err", err, 0);

        // Nominal back-to-back vector.
        for (int i = 0; i < NI; i++) vec[i] = DW'(i + 1);
        run_vec(0, 0);
        chk("nom_ninput_pulses", niq.size(), NI);
        for (int i = 0; i < NI && i < niq.size(); i++) chk("nom_ninput_val", niq[i], i + 1);
        chk_outs("nom", 16'h0010, 16'h0020, 16'h0030);
        if (outcyc.size() == NN) begin
            chk("nom_consecutive1", outcyc[1] - outcyc[0], 1);
            chk("nom_consecutive2", outcyc[2] - outcyc[1], 1);
        end
        chk("nom_err", err, 0);

        // Upstream bubbles, staggered neuron arrival 2,0,1.
        for (int i = 0; i < NI; i++) vec[i] = DW'(16'h0a0 + i);
        set_neurons(7, 9, 5, 16'h1111, 16'h2222, 16'h3333);
        run_vec(1, 0);
        chk("bub_ninput_pulses", niq.size(), NI);
        for (int i = 0; i < NI && i < niq.size(); i++) chk("bub_ninput_val", niq[i], vec[i]);
        chk_outs("bub", 16'h1111, 16'h2222, 16'h3333);

        // Downstream backpressure.
        set_neurons(6, 6, 6, 16'h0abc, 16'h0def, 16'h0123);
        run_vec(0, 1);
        chk_outs("bp", 16'h0abc, 16'h0def, 16'h0123);
        chk("bp_in_ready_in_drain", ir_in_drain, 0);
        chk("bp_err", err, 0);

        // Neuron 1 never responds.
        set_neurons(6, 0, 6, 16'h0010, 16'h0020, 16'h0030);
        run_vec(0, 0);
        chk_outs("to", 16'h0010, 16'h0000, 16'h0030);
        chk("to_err", err, 1);

        // Reset part-way through FEED, then a clean vector.
        set_neurons(6, 6, 6, 16'h0010, 16'h0020, 16'h0030);
        start_vec(0, 0);
        guard = 0;
        while (npulse < 2 && guard < 50) begin step(); guard++; end
        chk("rst_mid_reached", npulse, 2);
        rst = 1'b1; quiet = 1'b1; fire_cyc = -1;
        step(); step();
        rst = 1'b0;
        chk("rst_err", err, 0);
        chk("rst_n_input", n_input, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_data", out_data, 0);
        step();
        for (int i = 0; i < NI; i++) vec[i] = DW'(i + 5);
        run_vec(0, 0);
        chk("rst2_ninput_pulses", niq.size(), NI);
        for (int i = 0; i < NI && i < niq.size(); i++) chk("rst2_ninput_val", niq[i], i + 5);
        chk_outs("rst2", 16'h0010, 16'h0020, 16'h0030);
        chk("rst2_err", err, 0);

        // Duplicate pulse in WAIT, then a spurious one in IDLE.
        set_neurons(6, 12, 12, 16'h0111, 16'h0222, 16'h0333);
        dupd[0] = 9;
        run_vec(0, 0);
        chk_outs("dup", 16'h0111, 16'h0222, 16'h0333);
        chk("dup_err", err, 1);
        spur = 1'b1; step(); spur = 1'b0; step(); step();
        chk("spur_err_sticky", err, 1);
        do_reset();
        chk("dup_err_cleared", err, 0);

        // Randomized vectors.
        for (int t = 0; t < 10; t++) begin
            for (int i = 0; i < NI; i++) vec[i] = DW'($urandom);
            for (int k = 0; k < NN; k++) begin
                dly[k]  = $urandom_range(1, 12);
                nval[k] = DW'($urandom);
                dupd[k] = 0;
            end
            if ($urandom_range(0, 4) == 0) dly[$urandom_range(0, NN - 1)] = 0;
            for (int k = 0; k < NN; k++) exp_o[k] = (dly[k] == 0) ? 16'h0 : nval[k];
            run_vec(2, 2);
            chk_outs("rand", exp_o[0], exp_o[1], exp_o[2]);
            chk("rand_ninput_pulses", niq.size(), NI);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
